// File: rtl/stage3_fetch_request_unit.sv
// Fetch stage of the 3-stage pipeline: owns the PC, issues instruction-bus
// reads, absorbs bus wait states, drains a request orphaned by a redirect,
// and registers the IF/EX latch.
module stage3_fetch_request_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_en,
  input  logic        npc_sel,
  input  logic [31:0] brj_addr,
  input  logic        insert_priv_pc,
  input  logic [31:0] priv_pc,
  input  logic        if_ex_stall,
  input  logic        if_ex_flush,
  input  logic        iren,
  input  logic        suppress_iren,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  output logic        i_mem_busy,
  output logic [31:0] pc_f,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_pc4,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  output logic        fetch_mal,
  output logic [31:0] fetch_badaddr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drain_addr;
  logic        mis;
  logic        done;
  logic        redirect;
  logic        load_ok;

  assign mis      = (pc[1:0] != 2'b00);
  assign redirect = insert_priv_pc | npc_sel;
  assign pc_f     = pc;

  // Bus request, completion and next-state/next-PC selection.
  always_comb begin
    imem_ren   = 1'b0;
    imem_addr  = {pc[31:2], 2'b00};
    done       = 1'b0;
    i_mem_busy = 1'b0;
    state_nxt  = state;
    pc_nxt     = pc;
    unique case (state)
      FETCH: begin
        imem_ren   = iren & ~suppress_iren & ~mis;
        done       = (imem_ren & ~imem_busy) | (mis & iren);
        i_mem_busy = iren & ~done;
        if (redirect && imem_ren && imem_busy) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Hold the orphaned request stable until the bus completes it;
        // its response is thrown away.
        imem_ren   = 1'b1;
        imem_addr  = drain_addr;
        i_mem_busy = 1'b1;
        if (!imem_busy) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (insert_priv_pc)             pc_nxt = priv_pc;
    else if (npc_sel)               pc_nxt = brj_addr;
    else if (pc_en && done)         pc_nxt = pc + 32'd4;
  end

  assign load_ok = (state == FETCH) & done & ~redirect;

  // PC, FSM state and drain address registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH && state_nxt == DRAIN) drain_addr <= imem_addr;
    end
  end

  // IF/EX latch: flush beats stall beats load; a non-loading cycle bubbles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_valid   <= 1'b0;
      fetch_fault   <= 1'b0;
      fetch_mal     <= 1'b0;
      fetch_pc      <= '0;
      fetch_pc4     <= '0;
      fetch_instr   <= '0;
      fetch_badaddr <= '0;
    end else if (if_ex_flush) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_mal   <= 1'b0;
    end else if (!if_ex_stall) begin
      if (load_ok) begin
        fetch_valid   <= 1'b1;
        fetch_pc      <= pc;
        fetch_pc4     <= pc + 32'd4;
        fetch_instr   <= (imem_fault | mis) ? NOP : imem_rdata;
        fetch_fault   <= imem_fault;
        fetch_mal     <= mis;
        fetch_badaddr <= (imem_fault | mis) ? pc : '0;
      end else begin
        fetch_valid <= 1'b0;
        fetch_fault <= 1'b0;
        fetch_mal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage3_fetch_request_unit.sv
// Directed bench for the fetch stage; the bus model returns addr ^ 32'h1234_5678.
module tb_stage3_fetch_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, npc_sel, insert_priv_pc, if_ex_stall, if_ex_flush;
  logic        iren, suppress_iren, imem_busy, imem_fault;
  logic [31:0] brj_addr, priv_pc, imem_rdata;
  logic        imem_ren, i_mem_busy, fetch_valid, fetch_fault, fetch_mal;
  logic [31:0] imem_addr, pc_f, fetch_pc, fetch_pc4, fetch_instr, fetch_badaddr;

  int checks = 0;
  int errors = 0;

  stage3_fetch_request_unit #(.RESET_PC(32'h8000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .npc_sel(npc_sel), .brj_addr(brj_addr),
    .insert_priv_pc(insert_priv_pc), .priv_pc(priv_pc), .if_ex_stall(if_ex_stall),
    .if_ex_flush(if_ex_flush), .iren(iren), .suppress_iren(suppress_iren),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_busy(imem_busy),
    .imem_rdata(imem_rdata), .imem_fault(imem_fault), .i_mem_busy(i_mem_busy),
    .pc_f(pc_f), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pc4(fetch_pc4),
    .fetch_instr(fetch_instr), .fetch_fault(fetch_fault), .fetch_mal(fetch_mal),
    .fetch_badaddr(fetch_badaddr)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; pc_en = 1'b1; npc_sel = 1'b0; insert_priv_pc = 1'b0;
    if_ex_stall = 1'b0; if_ex_flush = 1'b0; iren = 1'b1; suppress_iren = 1'b0;
    imem_busy = 1'b0; imem_fault = 1'b0; brj_addr = '0; priv_pc = '0;

    repeat (2) @(negedge CLK);
    chk("rst_pc", pc_f, 32'h8000_0000);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_fpc", fetch_pc, 0);
    chk("rst_instr", fetch_instr, 0);
    chk("rst_badaddr", fetch_badaddr, 0);
    chk("rst_mal", fetch_mal, 0);

    adv(); nRST = 1'b1;
    @(negedge CLK);                        // c1
    chk("c1_ren", imem_ren, 1);
    chk("c1_addr", imem_addr, 32'h8000_0000);
    chk("c1_valid", fetch_valid, 0);

    adv(); imem_busy = 1'b1;
    @(negedge CLK);                        // c2: first wait cycle
    chk("c2_addr", imem_addr, 32'h8000_0004);
    chk("c2_valid", fetch_valid, 1);
    chk("c2_fpc", fetch_pc, 32'h8000_0000);
    chk("c2_pc4", fetch_pc4, 32'h8000_0004);
    chk("c2_instr", fetch_instr, mem(32'h8000_0000));
    chk("c2_busy", i_mem_busy, 1);

    adv();
    @(negedge CLK);                        // c3
    chk("c3_busy", i_mem_busy, 1);
    chk("c3_valid", fetch_valid, 0);

    adv();
    @(negedge CLK);                        // c4
    chk("c4_busy", i_mem_busy, 1);
    chk("c4_addr", imem_addr, 32'h8000_0004);

    adv(); imem_busy = 1'b0;
    @(negedge CLK);                        // c5: completes
    chk("c5_busy", i_mem_busy, 0);
    chk("c5_valid", fetch_valid, 0);

    adv(); imem_busy = 1'b1; npc_sel = 1'b1; brj_addr = 32'h8000_0100;
    @(negedge CLK);                        // c6: redirect while busy
    chk("c6_valid", fetch_valid, 1);
    chk("c6_fpc", fetch_pc, 32'h8000_0004);
    chk("c6_instr", fetch_instr, mem(32'h8000_0004));
    chk("c6_addr", imem_addr, 32'h8000_0008);

    adv(); npc_sel = 1'b0;
    @(negedge CLK);                        // c7: draining
    chk("c7_addr", imem_addr, 32'h8000_0008);
    chk("c7_ren", imem_ren, 1);
    chk("c7_busy", i_mem_busy, 1);
    chk("c7_pc", pc_f, 32'h8000_0100);
    chk("c7_valid", fetch_valid, 0);

    adv(); imem_busy = 1'b0;
    @(negedge CLK);                        // c8: drained response discarded
    chk("c8_addr", imem_addr, 32'h8000_0008);
    chk("c8_busy", i_mem_busy, 1);

    adv();
    @(negedge CLK);                        // c9
    chk("c9_addr", imem_addr, 32'h8000_0100);
    chk("c9_valid", fetch_valid, 0);
    chk("c9_busy", i_mem_busy, 0);

    adv(); insert_priv_pc = 1'b1; priv_pc = 32'h8000_0200; npc_sel = 1'b1; brj_addr = 32'h8000_0300;
    @(negedge CLK);                        // c10
    chk("c10_valid", fetch_valid, 1);
    chk("c10_fpc", fetch_pc, 32'h8000_0100);
    chk("c10_pc", pc_f, 32'h8000_0104);

    adv(); insert_priv_pc = 1'b0; npc_sel = 1'b0;
    @(negedge CLK);                        // c11
    chk("c11_pc", pc_f, 32'h8000_0200);
    chk("c11_addr", imem_addr, 32'h8000_0200);
    chk("c11_valid", fetch_valid, 0);

    adv(); npc_sel = 1'b1; brj_addr = 32'h8000_0102;
    @(negedge CLK);                        // c12
    chk("c12_fpc", fetch_pc, 32'h8000_0200);
    chk("c12_instr", fetch_instr, mem(32'h8000_0200));

    adv(); npc_sel = 1'b0;
    @(negedge CLK);                        // c13: misaligned PC
    chk("c13_pc", pc_f, 32'h8000_0102);
    chk("c13_ren", imem_ren, 0);
    chk("c13_busy", i_mem_busy, 0);

    adv(); npc_sel = 1'b1; brj_addr = 32'h8000_0400;
    @(negedge CLK);                        // c14
    chk("c14_valid", fetch_valid, 1);
    chk("c14_mal", fetch_mal, 1);
    chk("c14_badaddr", fetch_badaddr, 32'h8000_0102);
    chk("c14_instr", fetch_instr, 32'h0000_0013);
    chk("c14_fpc", fetch_pc, 32'h8000_0102);
    chk("c14_fault", fetch_fault, 0);

    adv(); npc_sel = 1'b0;
    @(negedge CLK);                        // c15
    chk("c15_pc", pc_f, 32'h8000_0400);
    chk("c15_valid", fetch_valid, 0);
    chk("c15_mal", fetch_mal, 0);

    adv(); if_ex_flush = 1'b1; if_ex_stall = 1'b1;
    @(negedge CLK);                        // c16
    chk("c16_valid", fetch_valid, 1);
    chk("c16_instr", fetch_instr, mem(32'h8000_0400));

    adv(); if_ex_flush = 1'b0; if_ex_stall = 1'b0;
    @(negedge CLK);                        // c17: flush won over stall
    chk("c17_flush_valid", fetch_valid, 0);
    chk("c17_pc", pc_f, 32'h8000_0408);

    adv(); if_ex_stall = 1'b1; pc_en = 1'b0;
    @(negedge CLK);                        // c18
    chk("c18_valid", fetch_valid, 1);
    chk("c18_fpc", fetch_pc, 32'h8000_0408);

    adv();
    @(negedge CLK);                        // c19: held
    chk("c19_fpc", fetch_pc, 32'h8000_0408);
    chk("c19_instr", fetch_instr, mem(32'h8000_0408));
    chk("c19_valid", fetch_valid, 1);
    chk("c19_pc", pc_f, 32'h8000_040C);

    adv();
    @(negedge CLK);                        // c20: still held
    chk("c20_fpc", fetch_pc, 32'h8000_0408);
    chk("c20_valid", fetch_valid, 1);
    if_ex_stall = 1'b0; pc_en = 1'b1; imem_fault = 1'b1;

    adv(); imem_fault = 1'b0; npc_sel = 1'b1; brj_addr = 32'hFFFF_FFFC;
    @(negedge CLK);                        // c21: access fault latched
    chk("c21_fault", fetch_fault, 1);
    chk("c21_instr", fetch_instr, 32'h0000_0013);
    chk("c21_badaddr", fetch_badaddr, 32'h8000_040C);
    chk("c21_fpc", fetch_pc, 32'h8000_040C);
    chk("c21_mal", fetch_mal, 0);

    adv(); npc_sel = 1'b0;
    @(negedge CLK);                        // c22
    chk("c22_pc", pc_f, 32'hFFFF_FFFC);

    adv(); imem_busy = 1'b1; npc_sel = 1'b1; brj_addr = 32'h8000_0500;
    @(negedge CLK);                        // c23: wrapped
    chk("c23_pc", pc_f, 32'h0000_0000);
    chk("c23_fpc", fetch_pc, 32'hFFFF_FFFC);
    chk("c23_pc4", fetch_pc4, 32'h0000_0000);

    adv(); npc_sel = 1'b0;
    @(negedge CLK);                        // c24: draining, then async reset
    chk("c24_addr", imem_addr, 32'h0000_0000);
    chk("c24_pc", pc_f, 32'h8000_0500);
    chk("c24_busy", i_mem_busy, 1);
    #1 imem_busy = 1'b0; nRST = 1'b0;
    #1;
    chk("rst2_pc", pc_f, 32'h8000_0000);
    chk("rst2_busy", i_mem_busy, 0);
    chk("rst2_addr", imem_addr, 32'h8000_0000);
    chk("rst2_valid", fetch_valid, 0);

    adv(); nRST = 1'b1; suppress_iren = 1'b1;
    @(negedge CLK);
    chk("sup_ren", imem_ren, 0);
    chk("sup_busy", i_mem_busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
